alu_share_arbiter: RTL

//  Shares one WIDTH-bit ALU between two requesters (port 0 / port 1) in the user project area.

---
 rtl/alu_share_arbiter_if.sv | 24 ++
 rtl/alu_share_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter_if.sv
// One requester's operand channel plus its one-deep response buffer.
// The requester side uses the master modport, the arbiter the slave modport.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [1:0]       req_op;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH:0]   rsp_data;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one WIDTH-bit ALU between two requesters.
// Round-robin grant in IDLE, one EXEC cycle computes and loads the response
// buffer of the granted port. A port whose response is still unconsumed is skipped.
module alu_share_arbiter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  alu_share_arbiter_if.slave  port0,
  alu_share_arbiter_if.slave  port1,
  output logic                busy,
  output logic [CNT_W-1:0]    op_count
);

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic             last_grant_r;
  logic             grant_s;
  logic             accept_s;
  logic             elig0_s;
  logic             elig1_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [1:0]       op_r;
  logic [WIDTH:0]   result_s;
  logic             rsp0_valid_r;
  logic             rsp1_valid_r;
  logic [WIDTH:0]   rsp0_data_r;
  logic [WIDTH:0]   rsp1_data_r;
  logic [CNT_W-1:0] op_count_r;

  // ALU: MSB is carry for ADD, borrow for SUB, zero for logic ops.
  function automatic logic [WIDTH:0] alu_eval(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [1:0]       op
  );
    logic [WIDTH:0] r;
    case (op)
      2'b00:   r = {1'b0, a} + {1'b0, b};
      2'b01:   r = {(a < b), a - b};
      2'b10:   r = {1'b0, a & b};
      2'b11:   r = {1'b0, a | b};
      default: r = {(WIDTH+1){1'b0}};
    endcase
    return r;
  endfunction

  // A port may be served if it requests and its response slot frees this cycle.
  assign elig0_s = port0.req_valid && (!rsp0_valid_r || port0.rsp_ready);
  assign elig1_s = port1.req_valid && (!rsp1_valid_r || port1.rsp_ready);

  // Next-state and grant selection; ties go to the port not granted last.
  always_comb begin
    state_s  = state_r;
    grant_s  = 1'b0;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (elig0_s && elig1_s) begin
          grant_s = ~last_grant_r;
        end else if (elig1_s) begin
          grant_s = 1'b1;
        end else begin
          grant_s = 1'b0;
        end
        accept_s = elig0_s || elig1_s;
        if (accept_s) begin
          state_s = EXEC;
        end else begin
          state_s = IDLE;
        end
      end
      EXEC:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  assign port0.req_ready = accept_s && !grant_s;
  assign port1.req_ready = accept_s && grant_s;
  assign result_s        = alu_eval(a_r, b_r, op_r);

  // Sequencer state, grant history and captured operands.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      a_r          <= {WIDTH{1'b0}};
      b_r          <= {WIDTH{1'b0}};
      op_r         <= 2'b00;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        last_grant_r <= grant_s;
        a_r          <= grant_s ? port1.req_a  : port0.req_a;
        b_r          <= grant_s ? port1.req_b  : port0.req_b;
        op_r         <= grant_s ? port1.req_op : port0.req_op;
      end
    end
  end

  // Response buffers and completed-op counter; EXEC loads the granted port.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rsp0_valid_r <= 1'b0;
      rsp1_valid_r <= 1'b0;
      rsp0_data_r  <= {(WIDTH+1){1'b0}};
      rsp1_data_r  <= {(WIDTH+1){1'b0}};
      op_count_r   <= {CNT_W{1'b0}};
    end else begin
      if (state_r == EXEC) begin
        op_count_r <= op_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if ((state_r == EXEC) && !last_grant_r) begin
        rsp0_valid_r <= 1'b1;
        rsp0_data_r  <= result_s;
      end else if (rsp0_valid_r && port0.rsp_ready) begin
        rsp0_valid_r <= 1'b0;
      end
      if ((state_r == EXEC) && last_grant_r) begin
        rsp1_valid_r <= 1'b1;
        rsp1_data_r  <= result_s;
      end else if (rsp1_valid_r && port1.rsp_ready) begin
        rsp1_valid_r <= 1'b0;
      end
    end
  end

  assign port0.rsp_valid = rsp0_valid_r;
  assign port0.rsp_data  = rsp0_data_r;
  assign port1.rsp_valid = rsp1_valid_r;
  assign port1.rsp_data  = rsp1_data_r;
  assign busy            = (state_r == EXEC);
  assign op_count        = op_count_r;

endmodule
